// File: rtl/comparator_pkg.sv
// Shared decision encoding and stage-count helper for the pipelined comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_t;

  function automatic int stage_count(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/comparator_stage.sv
// One pipeline stage: compares chunk IDX (0 = MSB chunk) when the incoming
// decision is still EQ, then registers valid, decision, operands and decoded flags.
module comparator_stage
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  cmp_t             dec_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             valid,
  output cmp_t             dec,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int HI = WIDTH - 1 - IDX * CHUNK;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  cmp_t             dec_next;

  assign a_chunk = a_in[HI -: CHUNK];
  assign b_chunk = b_in[HI -: CHUNK];

  // A more significant chunk already decided the result; only EQ is refined.
  always_comb begin
    dec_next = dec_in;
    if (dec_in == CMP_EQ) begin
      if (a_chunk > b_chunk)      dec_next = CMP_GT;
      else if (a_chunk < b_chunk) dec_next = CMP_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dec   <= CMP_EQ;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else if (en) begin
      valid <= valid_in;
      dec   <= dec_next;
      gt    <= valid_in && (dec_next == CMP_GT);
      lt    <= valid_in && (dec_next == CMP_LT);
      eq    <= valid_in && (dec_next == CMP_EQ);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a <= a_in;
      b <= b_in;
    end
  end

endmodule

// File: rtl/comparator_pipe.sv
// Pipelined magnitude comparator: MSB-chunk-first over STAGES cycles, whole-pipe
// stall on backpressure, signed mode via MSB inversion, saturating equal counter.
module comparator_pipe
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  input  logic             clr_count,
  output logic [CNT_W-1:0] eq_count
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             valid_s [STAGES+1];
  cmp_t             dec_s   [STAGES+1];
  logic [WIDTH-1:0] a_s     [STAGES+1];
  logic [WIDTH-1:0] b_s     [STAGES+1];
  logic             gt_s    [STAGES];
  logic             lt_s    [STAGES];
  logic             eq_s    [STAGES];
  logic [WIDTH-1:0] sign_mask;
  logic             unused_bits;

  assign in_ready = ~(out_valid & ~out_ready);

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  assign sign_mask  = WIDTH'(signed_mode) << (WIDTH - 1);
  assign valid_s[0] = in_valid;
  assign dec_s[0]   = CMP_EQ;
  assign a_s[0]     = A ^ sign_mask;
  assign b_s[0]     = B ^ sign_mask;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      comparator_stage #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK),
        .IDX  (gi)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (in_ready),
        .valid_in(valid_s[gi]),
        .dec_in  (dec_s[gi]),
        .a_in    (a_s[gi]),
        .b_in    (b_s[gi]),
        .valid   (valid_s[gi+1]),
        .dec     (dec_s[gi+1]),
        .a       (a_s[gi+1]),
        .b       (b_s[gi+1]),
        .gt      (gt_s[gi]),
        .lt      (lt_s[gi]),
        .eq      (eq_s[gi])
      );
    end
  endgenerate

  assign out_valid = valid_s[STAGES];
  assign A_gt_B    = gt_s[STAGES-1];
  assign A_lt_B    = lt_s[STAGES-1];
  assign A_eq_B    = eq_s[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      eq_count <= '0;
    end else if (out_valid && out_ready && A_eq_B && (eq_count != CNT_MAX)) begin
      eq_count <= eq_count + 1'b1;
    end
  end

  // Intermediate flags and final-stage operands have no consumer.
  always_comb begin
    unused_bits = ^{a_s[STAGES], b_s[STAGES], dec_s[STAGES]};
    for (int i = 0; i < STAGES - 1; i++) begin
      unused_bits = unused_bits ^ gt_s[i] ^ lt_s[i] ^ eq_s[i];
    end
  end

endmodule

// File: tb/tb_comparator_pipe.sv
// Directed bench for comparator_pipe: vector table with latency checks plus
// hand-written back-to-back, stall, saturation/clear and mid-flight reset sequences.
module tb_comparator_pipe;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int CNT_W  = 8;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             A_gt_B;
  logic             A_lt_B;
  logic             A_eq_B;
  logic             clr_count;
  logic [CNT_W-1:0] eq_count;

  comparator_pipe #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A_gt_B     (A_gt_B),
    .A_lt_B     (A_lt_B),
    .A_eq_B     (A_eq_B),
    .clr_count  (clr_count),
    .eq_count   (eq_count)
  );

  // Expected flags are {gt, lt, eq}.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  exp;
  } vec_t;

  vec_t       vecs [11];
  logic [2:0] exp_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         n_hs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Every delivered result is compared, in order, against what was issued.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result_flags", int'({A_gt_B, A_lt_B, A_eq_B}), int'(exp_q.pop_front()));
    end
  end

  task automatic present(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [2:0] e);
    @(posedge clk);
    #1;
    A = a;
    B = b;
    signed_mode = s;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic stop_input();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int got;
    int first;
    int last;
    int cnt;
    int hs0;

    vecs[0]  = '{16'h1234, 16'h1243, 1'b0, 3'b010};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b010};
    vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 3'b100};
    vecs[3]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b010};
    vecs[4]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b100};
    vecs[5]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b001};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 3'b001};
    vecs[7]  = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b010};
    vecs[8]  = '{16'h1230, 16'h1203, 1'b0, 3'b100};
    vecs[9]  = '{16'h0005, 16'h0004, 1'b1, 3'b100};
    vecs[10] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100};

    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    signed_mode = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_flags", int'({A_gt_B, A_lt_B, A_eq_B}), 0);
    chk("reset_eq_count", eq_count, 0);
    chk("reset_in_ready", in_ready, 1);

    // Single vectors: latency and flags.
    for (int i = 0; i < 11; i++) begin
      present(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
      stop_input();
      lat = 1;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
        @(negedge clk);
        if (out_valid) got = 1;
        else begin
          @(posedge clk);
          lat++;
        end
      end
      chk($sformatf("latency_vec%0d", i), lat, STAGES);
      drain($sformatf("drain_vec%0d", i));
    end

    // Back-to-back: gt, lt, eq, gt on consecutive cycles.
    present(16'h0005, 16'h0003, 1'b0, 3'b100);
    present(16'h0100, 16'h0200, 1'b0, 3'b010);
    present(16'h4242, 16'h4242, 1'b0, 3'b001);
    present(16'h9000, 16'h8FFF, 1'b0, 3'b100);
    stop_input();
    first = -1;
    last = -1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = k;
        last = k;
        cnt++;
      end
    end
    chk("b2b_count", cnt, 4);
    chk("b2b_consecutive", last - first, 3);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Fill the pipe, then hold out_ready low for 3 cycles.
    hs0 = n_hs;
    present(16'h0005, 16'h0003, 1'b0, 3'b100);
    present(16'h0100, 16'h0200, 1'b0, 3'b010);
    present(16'h4242, 16'h4242, 1'b0, 3'b001);
    present(16'h9000, 16'h8FFF, 1'b0, 3'b100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_flags", int'({A_gt_B, A_lt_B, A_eq_B}), 3'b100);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("stall_drain");
    chk("stall_delivered", n_hs - hs0, 4);

    // Saturation of eq_count.
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    for (int i = 0; i < 300; i++) present(16'(i * 7), 16'(i * 7), 1'(i & 1), 3'b001);
    stop_input();
    drain("sat_drain");
    chk("sat_eq_count", eq_count, 255);

    // clr_count coinciding with an equal handshake.
    present(16'h5555, 16'h5555, 1'b0, 3'b001);
    stop_input();
    repeat (3) @(posedge clk);
    #1;
    clr_count = 1'b1;
    @(negedge clk);
    chk("clr_same_cycle_hs", int'({out_valid, out_ready, A_eq_B}), 3'b111);
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    chk("clr_wins", eq_count, 0);
    present(16'h0777, 16'h0777, 1'b1, 3'b001);
    stop_input();
    drain("count_resume_drain");
    chk("count_resume", eq_count, 1);

    // Reset with three results in flight.
    present(16'h0001, 16'h0002, 1'b0, 3'b010);
    present(16'h0003, 16'h0003, 1'b0, 3'b001);
    present(16'h0009, 16'h0002, 1'b0, 3'b100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    hs0 = n_hs;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_flags", int'({A_gt_B, A_lt_B, A_eq_B}), 0);
    chk("rst_mid_eq_count", eq_count, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("rst_no_survivors", n_hs - hs0, 0);
    present(16'hC000, 16'h3000, 1'b1, 3'b010);
    stop_input();
    drain("post_reset_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
